mode_sequencer: RTL and testbench
=================================

# mode_sequencer

Parametrised front-panel mode/step sequencer: turns debounced navigation and confirm buttons into a mode register and a per-mode step index that ends in an EXECUTE step. Generalises the fixed 4-bit mode / 2-bit step selector with configurable widths, a per-mode step-count table, internal edge detection, a back button, a mode lock, wrap or saturate navigation, and status pulses. It sits between the button debouncers and the datapath controller, which consumes `mode_o`, `state_o` and `exec_o`.

## Interface
- `MODE_W`, 4: mode register width; there are 2**MODE_W modes.
- `STEP_W`, 2: step index width. The EXEC step is all-ones (2**STEP_W-1).
- `NSTEP`, 32'h5FFD_AA97: packed table of 2**MODE_W fields, each STEP_W wide. Field m, at bits [m*STEP_W +: STEP_W], gives the number of entry steps for mode m. A field value of 0 is treated as 1.
- `WRAP`, 1: 1 means left/right wrap modulo 2**MODE_W; 0 means saturate at 0 and at 2**MODE_W-1.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `up_i`, `left_i`, `right_i` input 1 each: debounced navigation levels, already synchronous to `clk`.
- `confirm_i`, `back_i` input 1 each: debounced step-advance and step-retreat levels.
- `lock_i` input 1: when high, navigation is ignored and confirm/back still act.
- `mode_o` output MODE_W: current mode.
- `state_o` output STEP_W: current step.
- `exec_o` output 1: high while `state_o` equals the EXEC step.
- `done_o` output 1: one-cycle pulse on entering EXEC.
- `mode_chg_o` output 1: one-cycle pulse when `mode_o` changes value.

## Operation
- **Edge detection:** each of the five buttons has a history register. An event occurs when the input is 1 and its history bit is 0. Events act only on rising edges; holding a button does nothing further.
- **Navigation:** valid only when exactly one of up/left/right has an event and `lock_i`=0. Two or more simultaneous nav events are discarded.
  - up: toggle `mode_o[MODE_W-1]`.
  - left: mode-1, with wrap or saturate per WRAP.
  - right: mode+1, with wrap or saturate per WRAP.
  - Any valid nav sets the step to 0, even if the mode value does not change (saturated).
- **Step sequence** for mode m, with K = NSTEP field m: 0 → 1 → … → K-1 → EXEC → 0. Confirm advances one position.
  - If K ≥ EXEC, the entry steps stop at EXEC-1 and the next confirm goes to EXEC.
  - Back retreats one position: EXEC → K-1, s → s-1, 0 stays at 0.
- **Priority:**
  - A valid nav overrides confirm/back in the same cycle.
  - Confirm and back events together cause no step change.
  - Discarded nav (multiple events, or locked) leaves confirm/back processing unaffected.
- **Pulses:**
  - `done_o` pulses on the cycle the step becomes EXEC.
  - `mode_chg_o` pulses only when the mode value actually differs from its previous value.

## Timing
- **Reset** (`rst` high at a clock edge): `mode_o`=0, `state_o`=0, `exec_o`=0, `done_o`=0, `mode_chg_o`=0.
  - History registers load the current input levels during reset, so a button held through reset does not produce an event after release.
- **Latency:** an input that is first sampled high at edge n updates `mode_o`, `state_o`, `exec_o` and the pulses at edge n. Outputs are registered, and `exec_o` is decoded from the registered step.
- **Reset mid-sequence:** reset overrides all events in the same cycle; the step returns to 0 and the mode returns to 0.
- **Nav while in EXEC:** the step goes to 0, `exec_o` falls at the same edge, and `done_o` stays 0.
- **Lock:** `lock_i` is sampled in the same cycle as the event. A nav event that arrives while locked is consumed and is not replayed after unlock.

## Test plan
- **Reset and hold:** hold `right_i` high through reset, then release reset → `mode_o` stays 0, `mode_chg_o` stays 0.
- **Default table, mode 0:** four confirm pulses → `state_o` 0→1→2→3→0. `done_o` is high only on the edge that reaches 3. `exec_o` is high for exactly the interval between the 3rd and 4th pulses.
- **Short and medium sequences:**
  - Mode 1 (one right press), confirm → `state_o`=3 (EXEC) directly.
  - Mode 3, confirm ×2 → 1 then 3.
  - From EXEC in mode 3, back → 1.
- **Wrap/saturate:** at mode 0, left → 15 with WRAP=1. With WRAP=0 the mode stays 0, `state_o` goes to 0 and `mode_chg_o`=0. With `state_o`=2, up → `mode_o`=8 and `state_o`=0.
- **Simultaneous events:**
  - left+right together → mode unchanged.
  - left+right+confirm → step advances.
  - right+confirm → mode+1, step 0.
  - confirm+back → no change.
- **Lock:** with `lock_i`=1, right → no mode change and confirm still advances. Drop the lock without a new press → mode stays unchanged.

Source files
------------

// File: rtl/mode_sequencer.sv
// mode_sequencer: front-panel mode/step sequencer.
//
// Turns debounced navigation (up/left/right) and step (confirm/back) buttons into a mode
// register and a per-mode step index. Each mode m walks through K entry steps (K taken from
// the NSTEP table) and then the all-ones EXEC step, after which confirm returns to step 0.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   up_i         toggle the mode MSB (rising edge)
//   left_i       mode - 1, wrap or saturate (rising edge)
//   right_i      mode + 1, wrap or saturate (rising edge)
//   confirm_i    advance one step (rising edge)
//   back_i       retreat one step (rising edge)
//   lock_i       ignore navigation while high
//   mode_o       current mode
//   state_o      current step
//   exec_o       high while state_o is the EXEC step
//   done_o       one-cycle pulse on entering EXEC
//   mode_chg_o   one-cycle pulse when mode_o changes value
module mode_sequencer #(
  parameter int unsigned                    MODE_W = 4,
  parameter int unsigned                    STEP_W = 2,
  parameter logic [(2**MODE_W)*STEP_W-1:0] NSTEP  = 32'h5FFD_AA97,
  parameter bit                             WRAP   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up_i,
  input  logic              left_i,
  input  logic              right_i,
  input  logic              confirm_i,
  input  logic              back_i,
  input  logic              lock_i,
  output logic [MODE_W-1:0] mode_o,
  output logic [STEP_W-1:0] state_o,
  output logic              exec_o,
  output logic              done_o,
  output logic              mode_chg_o
);

  localparam logic [STEP_W-1:0] Exec    = '1;
  localparam logic [MODE_W-1:0] ModeMsb = {1'b1, {(MODE_W-1){1'b0}}};

  // Button bit order: {back, confirm, right, left, up}
  logic [4:0]        btn;
  logic [4:0]        hist_q;
  logic [4:0]        ev;
  logic              nav_ok;

  logic [MODE_W-1:0] mode_q, mode_d;
  logic [STEP_W-1:0] state_q, state_d;
  logic              done_q, chg_q;

  logic [STEP_W-1:0] k_raw;
  logic [STEP_W-1:0] k_last;

  assign btn = {back_i, confirm_i, right_i, left_i, up_i};
  assign ev  = btn & ~hist_q;

  // Exactly one navigation event and not locked; locked or colliding events are dropped.
  assign nav_ok = !lock_i && $onehot(ev[2:0]);

  // Last entry step of the current mode. A field of 0 behaves as 1; a field equal to EXEC
  // caps the entries at EXEC-1, which k_raw-1 already yields.
  assign k_raw  = NSTEP[STEP_W*mode_q +: STEP_W];
  assign k_last = (k_raw == '0) ? '0 : k_raw - STEP_W'(1);

  always_comb begin
    mode_d  = mode_q;
    state_d = state_q;
    if (nav_ok) begin
      unique case (1'b1)
        ev[0]: mode_d = mode_q ^ ModeMsb;
        ev[1]: if (WRAP || mode_q != '0) mode_d = mode_q - MODE_W'(1);
        ev[2]: if (WRAP || mode_q != '1) mode_d = mode_q + MODE_W'(1);
        default: mode_d = mode_q;
      endcase
      // Step clears on any accepted nav, even when saturation keeps the mode value.
      state_d = '0;
    end else if (ev[3] && !ev[4]) begin
      if (state_q == Exec)        state_d = '0;
      else if (state_q >= k_last) state_d = Exec;
      else                        state_d = state_q + STEP_W'(1);
    end else if (ev[4] && !ev[3]) begin
      if (state_q == Exec)        state_d = k_last;
      else if (state_q != '0)     state_d = state_q - STEP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // History follows the inputs even in reset so a held button gives no event afterwards.
    hist_q <= btn;
    if (rst) begin
      mode_q  <= '0;
      state_q <= '0;
      done_q  <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      state_q <= state_d;
      done_q  <= (state_d == Exec) && (state_q != Exec);
      chg_q   <= (mode_d != mode_q);
    end
  end

  assign mode_o     = mode_q;
  assign state_o    = state_q;
  assign exec_o     = (state_q == Exec);
  assign done_o     = done_q;
  assign mode_chg_o = chg_q;

endmodule

// File: tb/tb_mode_sequencer.sv
module tb_mode_sequencer;

  localparam logic [31:0] NSTEP = 32'h5FFD_AA97;
  localparam int EXEC = 3;

  logic clk = 1'b0;
  logic rst, up, left, right, conf, back, lock;

  logic [3:0] mode_w, mode_s;
  logic [1:0] state_w, state_s;
  logic       exec_w, exec_s, done_w, done_s, chg_w, chg_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mode_sequencer #(.MODE_W(4), .STEP_W(2), .NSTEP(NSTEP), .WRAP(1'b1)) dut (
    .clk(clk), .rst(rst), .up_i(up), .left_i(left), .right_i(right),
    .confirm_i(conf), .back_i(back), .lock_i(lock),
    .mode_o(mode_w), .state_o(state_w), .exec_o(exec_w), .done_o(done_w),
    .mode_chg_o(chg_w)
  );

  mode_sequencer #(.MODE_W(4), .STEP_W(2), .NSTEP(NSTEP), .WRAP(1'b0)) dut_sat (
    .clk(clk), .rst(rst), .up_i(up), .left_i(left), .right_i(right),
    .confirm_i(conf), .back_i(back), .lock_i(lock),
    .mode_o(mode_s), .state_o(state_s), .exec_o(exec_s), .done_o(done_s),
    .mode_chg_o(chg_s)
  );

  // Reference model: index 0 wraps, index 1 saturates. Position counts along the list
  // {0, 1, .., eff-1, EXEC} of the mode.
  int m_mode[2];
  int m_pos[2];
  bit m_done[2];
  bit m_chg[2];
  bit prev[5];

  function automatic int eff_of(int m);
    int k;
    k = (NSTEP >> (2 * m)) & 3;
    if (k == 0) k = 1;
    if (k > EXEC) k = EXEC;
    return k;
  endfunction

  function automatic int step_of(int w);
    return (m_pos[w] < eff_of(m_mode[w])) ? m_pos[w] : EXEC;
  endfunction

  task automatic model_clock(input bit r, lk, u, l, rt, c, b);
    bit in[5];
    bit ev[5];
    int nnav, old_mode, old_step;
    in = '{u, l, rt, c, b};
    if (r) begin
      for (int w = 0; w < 2; w++) begin
        m_mode[w] = 0; m_pos[w] = 0; m_done[w] = 0; m_chg[w] = 0;
      end
      prev = in;
      return;
    end
    for (int i = 0; i < 5; i++) ev[i] = in[i] && !prev[i];
    prev = in;
    nnav = int'(ev[0]) + int'(ev[1]) + int'(ev[2]);
    for (int w = 0; w < 2; w++) begin
      old_mode = m_mode[w];
      old_step = step_of(w);
      if (nnav == 1 && !lk) begin
        if (ev[0]) m_mode[w] = m_mode[w] ^ 8;
        else if (ev[1]) m_mode[w] = (w == 0) ? (m_mode[w] + 15) % 16
                                              : ((m_mode[w] > 0) ? m_mode[w] - 1 : 0);
        else m_mode[w] = (w == 0) ? (m_mode[w] + 1) % 16
                                  : ((m_mode[w] < 15) ? m_mode[w] + 1 : 15);
        m_pos[w] = 0;
      end else if (ev[3] && !ev[4]) begin
        m_pos[w] = (m_pos[w] + 1) % (eff_of(m_mode[w]) + 1);
      end else if (ev[4] && !ev[3]) begin
        if (m_pos[w] > 0) m_pos[w] = m_pos[w] - 1;
      end
      m_done[w] = (step_of(w) == EXEC) && (old_step != EXEC);
      m_chg[w]  = (m_mode[w] != old_mode);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("wrap.mode",  int'(mode_w),  m_mode[0]);
    chk("wrap.state", int'(state_w), step_of(0));
    chk("wrap.exec",  int'(exec_w),  int'(step_of(0) == EXEC));
    chk("wrap.done",  int'(done_w),  int'(m_done[0]));
    chk("wrap.chg",   int'(chg_w),   int'(m_chg[0]));
    chk("sat.mode",   int'(mode_s),  m_mode[1]);
    chk("sat.state",  int'(state_s), step_of(1));
    chk("sat.exec",   int'(exec_s),  int'(step_of(1) == EXEC));
    chk("sat.done",   int'(done_s),  int'(m_done[1]));
    chk("sat.chg",    int'(chg_s),   int'(m_chg[1]));
  endtask

  // Drive one cycle of inputs, clock it, then compare both DUTs with the model.
  task automatic tick(input bit r, lk, u, l, rt, c, b);
    rst = r; lock = lk; up = u; left = l; right = rt; conf = c; back = b;
    model_clock(r, lk, u, l, rt, c, b);
    @(posedge clk);
    #1;
    check_model();
  endtask

  typedef struct {
    bit r, lk, u, l, rt, c, b;
    int mode, state;
    bit exec, done, chg;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, lk, u, l, rt, c, b,
                     input int mode, state, input bit exec, done, chg);
    vec_t v;
    v.r = r; v.lk = lk; v.u = u; v.l = l; v.rt = rt; v.c = c; v.b = b;
    v.mode = mode; v.state = state; v.exec = exec; v.done = done; v.chg = chg;
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1'b1; lock = 0; up = 0; left = 0; right = 0; conf = 0; back = 0;

    //   r lk u l rt c b   mode st ex dn ch
    add(1, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0);  // right held through reset
    add(1, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0,  0, 1, 0, 0, 0);  // mode 0: 0->1->2->3->0
    add(0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0,  0, 2, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  0, 2, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0,  0, 3, 1, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0,  0, 3, 1, 0, 0);  // held confirm: nothing
    add(0, 0, 0, 0, 0, 0, 0,  0, 3, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,  1, 0, 0, 0, 1);  // mode 1: straight to EXEC
    add(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0,  1, 3, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0,  1, 3, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,  2, 0, 0, 0, 1);  // nav out of EXEC
    add(0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,  3, 0, 0, 0, 1);  // mode 3: 0->1->EXEC, back->1
    add(0, 0, 0, 0, 0, 0, 0,  3, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0,  3, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  3, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0,  3, 3, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0,  3, 3, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1,  3, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  3, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 11, 0, 0, 0, 1);  // up toggles MSB
    add(0, 0, 0, 0, 0, 0, 0, 11, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 15, 0, 0, 0, 1);  // left wraps to 15
    add(0, 0, 0, 0, 0, 0, 0, 15, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 1);  // right wraps to 0
    add(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0,  0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0,  0, 2, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  0, 2, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0,  8, 0, 0, 0, 1);  // state 2, up -> mode 8 step 0
    add(0, 0, 0, 0, 0, 0, 0,  8, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0,  8, 0, 0, 0, 0);  // left+right discarded
    add(0, 0, 0, 0, 0, 0, 0,  8, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 1, 0,  8, 3, 1, 1, 0);  // left+right+confirm advances
    add(0, 0, 0, 0, 0, 0, 0,  8, 3, 1, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0,  9, 0, 0, 0, 1);  // right beats confirm
    add(0, 0, 0, 0, 0, 0, 0,  9, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1,  9, 0, 0, 0, 0);  // confirm+back cancel
    add(0, 0, 0, 0, 0, 0, 0,  9, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 1, 0,  9, 1, 0, 0, 0);  // locked nav, confirm still acts
    add(0, 0, 0, 0, 1, 0, 0,  9, 1, 0, 0, 0);  // unlock with right still held
    add(0, 0, 0, 0, 0, 0, 0,  9, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1,  9, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  9, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1,  9, 0, 0, 0, 0);  // back at 0 stays
    add(0, 0, 0, 0, 0, 0, 0,  9, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0,  9, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  9, 1, 0, 0, 0);
    add(1, 0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 0);  // reset beats events
    add(0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      tick(tbl[i].r, tbl[i].lk, tbl[i].u, tbl[i].l, tbl[i].rt, tbl[i].c, tbl[i].b);
      chk($sformatf("row%0d.mode", i),  int'(mode_w),  tbl[i].mode);
      chk($sformatf("row%0d.state", i), int'(state_w), tbl[i].state);
      chk($sformatf("row%0d.exec", i),  int'(exec_w),  int'(tbl[i].exec));
      chk($sformatf("row%0d.done", i),  int'(done_w),  int'(tbl[i].done));
      chk($sformatf("row%0d.chg", i),   int'(chg_w),   int'(tbl[i].chg));
    end

    // Saturating instance: left at mode 0 from step 1 clears the step, no mode pulse.
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0, 0, 0);
    chk("sat.pre_state", int'(state_s), 1);
    tick(0, 0, 0, 1, 0, 0, 0);
    chk("sat.left_mode",  int'(mode_s),  0);
    chk("sat.left_state", int'(state_s), 0);
    chk("sat.left_chg",   int'(chg_s),   0);
    chk("wrap.left_mode", int'(mode_w),  15);

    // Randomised run against the model.
    for (int n = 0; n < 3000; n++) begin
      tick($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0,
           $urandom_range(0, 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
